// File: rtl/spi_dac_seq.sv
// spi_dac_seq: multi-channel SPI DAC sequencer.
// Accepts one update of up to NUM_CH channel words, sends one SPI frame per
// selected channel (ascending index, sync low per frame), then pulses ldac low
// once so every written channel updates together.
// Optional build macro SPI_DAC_SEQ_SKIP_UNCHANGED_EN: keep a per-channel shadow
// of the last word sent and drop channels whose requested word is unchanged.
//
// Handshake: an update is taken on any rising edge where s_valid && s_ready;
// s_ready is high only in IDLE outside reset, s_valid may be held high across
// back-to-back updates, and inputs are ignored on every other cycle.
module spi_dac_seq #(
   parameter int NUM_CH      = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int CLK_DIV     = 3,
   parameter int SYNC_GAP    = 2,
   parameter int LDAC_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
   input  logic [NUM_CH-1:0]            s_mask,
   input  logic [3:0]                   s_cmd,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic                         busy,
   output logic                         sync,
   output logic                         sclk,
   output logic                         sdi,
   output logic                         ldac,
   output logic [2:0]                   dbg_state_o
);

   localparam int FRAME_BITS = 8 + DATA_WIDTH;
   localparam int FRAME_CYC  = FRAME_BITS << CLK_DIV;
   localparam int GAP_CYC    = SYNC_GAP << CLK_DIV;
   localparam int MAX_FG     = (FRAME_CYC > GAP_CYC) ? FRAME_CYC : GAP_CYC;
   localparam int MAX_CYC    = (MAX_FG > LDAC_CYCLES) ? MAX_FG : LDAC_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYC + 1);

   // SELECT has no state of its own: the next channel is chosen
   // combinationally on the cycle that leaves IDLE or GAP.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FRAME = 3'd1,
      ST_GAP   = 3'd2,
      ST_LDAC  = 3'd3,
      ST_EMPTY = 3'd4
   } state_t;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [NUM_CH-1:0]              pend_q, pend_d;
   logic [3:0]                     ch_q, ch_d;
   logic [FRAME_BITS-1:0]          shift_q, shift_d;
   logic [NUM_CH*DATA_WIDTH-1:0]   data_q, data_d;
   logic [3:0]                     cmd_q, cmd_d;

   logic [NUM_CH-1:0]              eff_mask;
   logic [NUM_CH-1:0]              sel_mask;
   logic [NUM_CH*DATA_WIDTH-1:0]   sel_data;
   logic [3:0]                     sel_cmd;
   logic [3:0]                     sel_idx;
   logic [FRAME_BITS-1:0]          sel_word;
   logic                           frame_done;
   logic                           bit_end;

   // Lowest set bit of a channel mask (0 when the mask is empty).
   function automatic logic [3:0] lowest_idx(input logic [NUM_CH-1:0] m);
      logic [3:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) r = 4'(i);
      end
      return r;
   endfunction

   // Channel word mux written as a loop so the index never exceeds the range.
   function automatic logic [DATA_WIDTH-1:0] word_of(input logic [NUM_CH*DATA_WIDTH-1:0] d,
                                                     input logic [3:0] idx);
      logic [DATA_WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx == 4'(i)) w = d[i*DATA_WIDTH +: DATA_WIDTH];
      end
      return w;
   endfunction

   assign frame_done = (state_q == ST_FRAME) && (cnt_q == CNT_W'(FRAME_CYC - 1));
   assign bit_end    = (cnt_q[CLK_DIV-1:0] == {CLK_DIV{1'b1}});

`ifdef SPI_DAC_SEQ_SKIP_UNCHANGED_EN
   logic [DATA_WIDTH-1:0] shadow_q [NUM_CH];
   logic [NUM_CH-1:0]     shadow_vld_q;

   // Drop channels whose requested word equals the last word sent to them.
   always_comb begin
      eff_mask = s_mask;
      for (int i = 0; i < NUM_CH; i++) begin
         if (shadow_vld_q[i] && (s_data[i*DATA_WIDTH +: DATA_WIDTH] == shadow_q[i]))
            eff_mask[i] = 1'b0;
      end
   end

   // Record a channel's word once its frame has fully gone out.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_vld_q <= '0;
      end else if (frame_done) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == 4'(i)) begin
               shadow_vld_q[i] <= 1'b1;
               shadow_q[i]     <= word_of(data_q, ch_q);
            end
         end
      end
   end
`else
   assign eff_mask = s_mask;
`endif

   // Channel selection: live inputs when leaving IDLE, captured update otherwise.
   always_comb begin
      sel_mask = pend_q;
      sel_data = data_q;
      sel_cmd  = cmd_q;
      if (state_q == ST_IDLE) begin
         sel_mask = eff_mask;
         sel_data = s_data;
         sel_cmd  = s_cmd;
      end
      sel_idx  = lowest_idx(sel_mask);
      sel_word = {sel_cmd, sel_idx, word_of(sel_data, sel_idx)};
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ch_d    = ch_q;
      shift_d = shift_q;
      data_d  = data_q;
      cmd_d   = cmd_q;
      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               data_d = s_data;
               cmd_d  = s_cmd;
               cnt_d  = '0;
               pend_d = eff_mask;
               if (eff_mask == '0) begin
                  state_d = ST_EMPTY;
               end else begin
                  ch_d    = sel_idx;
                  shift_d = sel_word;
                  state_d = ST_FRAME;
               end
            end
         end
         ST_FRAME: begin
            cnt_d = cnt_q + 1'b1;
            if (bit_end) shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            if (frame_done) begin
               cnt_d = '0;
               for (int i = 0; i < NUM_CH; i++) begin
                  if (ch_q == 4'(i)) pend_d[i] = 1'b0;
               end
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
               cnt_d = '0;
               if (pend_q != '0) begin
                  ch_d    = sel_idx;
                  shift_d = sel_word;
                  state_d = ST_FRAME;
               end else begin
                  state_d = ST_LDAC;
               end
            end
         end
         ST_LDAC: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(LDAC_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_EMPTY: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset abandons any update in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ch_q    <= '0;
         shift_q <= '0;
         data_q  <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ch_q    <= ch_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         cmd_q   <= cmd_d;
      end
   end

   // Pin decode: sclk is the top bit of the in-bit cycle counter, so it is
   // low for the first half of each bit period and sdi only moves while low.
   assign s_ready     = (state_q == ST_IDLE) && !rst;
   assign busy        = (state_q != ST_IDLE);
   assign sync        = (state_q != ST_FRAME);
   assign sclk        = (state_q == ST_FRAME) && cnt_q[CLK_DIV-1];
   assign sdi         = (state_q == ST_FRAME) && shift_q[FRAME_BITS-1];
   assign ldac        = (state_q != ST_LDAC);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_dac_seq.sv
// tb_spi_dac_seq: directed bench for spi_dac_seq at default parameters.
// A pin monitor rebuilds SPI frames and ldac pulse widths; each update is
// compared against hand-chosen expected frames, duration and ldac pulse.
module tb_spi_dac_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] s_data;
   logic [7:0]   s_mask;
   logic [3:0]   s_cmd;
   logic         s_valid;
   logic         s_ready, busy, sync, sclk, sdi, ldac;
   logic [2:0]   dbg_state;

   int n_vec = 0;
   int n_err = 0;

   logic [23:0] exp_q[$];
   logic [23:0] got_q[$];
   int          gotn_q[$];
   int          ldac_q[$];

   spi_dac_seq dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_mask(s_mask), .s_cmd(s_cmd),
      .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .sync(sync),
      .sclk(sclk), .sdi(sdi), .ldac(ldac), .dbg_state_o(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Pin monitor: frames, bit counts, ldac widths, protocol violations.
   logic        prev_sclk = 1'b0;
   logic        prev_sync = 1'b1;
   logic        prev_ldac = 1'b1;
   logic [23:0] fsh = '0;
   int          fbits = 0;
   int          lw = 0;
   int          viol = 0;

   always @(negedge clk) begin
      if (sync && sclk) viol++;
      if (prev_ldac && !ldac && !sync) viol++;
      if (prev_sync && !sync) begin
         fsh   = '0;
         fbits = 0;
      end
      if (!prev_sclk && sclk) begin
         fsh = {fsh[22:0], sdi};
         fbits++;
      end
      if (!prev_sync && sync) begin
         got_q.push_back(fsh);
         gotn_q.push_back(fbits);
      end
      if (!ldac) lw++;
      if (!prev_ldac && ldac) begin
         ldac_q.push_back(lw);
         lw = 0;
      end
      prev_sclk = sclk;
      prev_sync = sync;
      prev_ldac = ldac;
   end

   // checker
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk_full(input logic [15:0] base);
      logic [127:0] r;
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = base + 16'(i);
      return r;
   endfunction

   // Expected frames: {cmd, channel index, data} for each channel, ascending.
   task automatic expect_frames(input logic [127:0] d, input logic [7:0] em,
                                input logic [3:0] c, output int k);
      k = 0;
      for (int i = 0; i < 8; i++) begin
         if (em[i]) begin
            exp_q.push_back({c, 4'(i), d[i*16 +: 16]});
            k++;
         end
      end
   endtask

   // Called on the first cycle after acceptance; counts s_ready-low cycles.
   task automatic wait_done(input int exp_d, input int k, input string tag);
      int          dcnt;
      logic [23:0] e;
      dcnt = 0;
      while (!s_ready && dcnt < 5000) begin
         dcnt++;
         @(negedge clk);
      end
      #1;
      check_eq({tag, "_dur"}, 32'(dcnt), 32'(exp_d));
      check_eq({tag, "_nframes"}, 32'(got_q.size()), 32'(k));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) begin
            check_eq({tag, "_frame"}, {8'h0, got_q.pop_front()}, {8'h0, e});
            check_eq({tag, "_bits"}, 32'(gotn_q.pop_front()), 32'd24);
         end else begin
            check_eq({tag, "_frame"}, 32'hFFFF_FFFF, {8'h0, e});
         end
      end
      check_eq({tag, "_nldac"}, 32'(ldac_q.size()), (k > 0) ? 32'd1 : 32'd0);
      if (ldac_q.size() > 0) check_eq({tag, "_ldacw"}, 32'(ldac_q.pop_front()), 32'd4);
      got_q.delete();
      gotn_q.delete();
      ldac_q.delete();
   endtask

   // Driver: present one update at negedge+1 with s_ready high.
   task automatic apply(input logic [127:0] d, input logic [7:0] m, input logic [3:0] c,
                        input logic [7:0] em, input int exp_d, input string tag);
      int k;
      s_data  = d;
      s_mask  = m;
      s_cmd   = c;
      s_valid = 1'b1;
      check_eq({tag, "_rdy"}, {31'h0, s_ready}, 32'd1);
      expect_frames(d, em, c, k);
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = ~d;
      s_mask  = ~m;
      s_cmd   = ~c;
      if (k > 0) begin
         check_eq({tag, "_sync0"}, {31'h0, sync}, 32'd0);
         check_eq({tag, "_msb"}, {31'h0, sdi}, {31'h0, c[3]});
      end else begin
         check_eq({tag, "_idle_sync"}, {31'h0, sync}, 32'd1);
         check_eq({tag, "_busy"}, {31'h0, busy}, 32'd1);
      end
      wait_done(exp_d, k, tag);
   endtask

   initial begin
      logic [127:0] d;
      int           k;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_mask  = '0;
      s_cmd   = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", {31'h0, s_ready}, 32'd0);
      check_eq("rst_busy", {31'h0, busy}, 32'd0);
      check_eq("rst_sync", {31'h0, sync}, 32'd1);
      check_eq("rst_sclk", {31'h0, sclk}, 32'd0);
      check_eq("rst_sdi", {31'h0, sdi}, 32'd0);
      check_eq("rst_ldac", {31'h0, ldac}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_eq("post_rst_ready", {31'h0, s_ready}, 32'd1);

      // full update: 8 frames, 8*208+4 cycles
      apply(mk_full(16'h1000), 8'hFF, 4'h3, 8'hFF, 1668, "full");

      // sparse update: frames 0x30ABCD then 0x321234, 2*208+4 cycles
      d = mk_full(16'h7700);
      d[15:0]  = 16'hABCD;
      d[47:32] = 16'h1234;
      apply(d, 8'h05, 4'h3, 8'h05, 420, "sparse");

      // empty mask: one cycle, no pins move
      apply(mk_full(16'h4000), 8'h00, 4'h5, 8'h00, 1, "empty");

      // reset at the 10th sclk rise of frame 0
      s_data  = mk_full(16'h5000);
      s_mask  = 8'hFF;
      s_cmd   = 4'h6;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      k = 0;
      while (k < 400) begin
         @(negedge clk);
         #1;
         if (fbits >= 10) break;
         k++;
      end
      check_eq("abort_rise10", 32'(fbits), 32'd10);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_sync", {31'h0, sync}, 32'd1);
      check_eq("abort_sclk", {31'h0, sclk}, 32'd0);
      check_eq("abort_ldac", {31'h0, ldac}, 32'd1);
      check_eq("abort_busy", {31'h0, busy}, 32'd0);
      check_eq("abort_rdy_in_rst", {31'h0, s_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("abort_rdy", {31'h0, s_ready}, 32'd1);
      repeat (300) @(negedge clk);
      #1;
      check_eq("abort_no_ldac", 32'(ldac_q.size()), 32'd0);
      check_eq("abort_idle", {31'h0, busy}, 32'd0);
      got_q.delete();
      gotn_q.delete();
      ldac_q.delete();

      // clean full update after the abort
      apply(mk_full(16'h2000), 8'hFF, 4'hA, 8'hFF, 1668, "full2");

      // back-to-back with s_valid held high
      d = '0;
      d[31:16] = 16'h5555;
      s_data  = d;
      s_mask  = 8'h02;
      s_cmd   = 4'h1;
      s_valid = 1'b1;
      expect_frames(d, 8'h02, 4'h1, k);
      @(negedge clk);
      d = '0;
      d[127:112] = 16'hFFFF;
      d[63:48]   = 16'h0F0F;
      s_data = d;
      s_mask = 8'h88;
      s_cmd  = 4'hC;
      check_eq("b2bA_sync0", {31'h0, sync}, 32'd0);
      wait_done(212, 1, "b2bA");
      expect_frames(d, 8'h88, 4'hC, k);
      @(negedge clk);
      s_valid = 1'b0;
      check_eq("b2bB_sync0", {31'h0, sync}, 32'd0);
      check_eq("b2bB_msb", {31'h0, sdi}, 32'd1);
      check_eq("b2bB_rdy", {31'h0, s_ready}, 32'd0);
      wait_done(420, 2, "b2bB");

`ifdef SPI_DAC_SEQ_SKIP_UNCHANGED_EN
      apply(mk_full(16'h3000), 8'hFF, 4'h3, 8'hFF, 1668, "skip_first");
      apply(mk_full(16'h3000), 8'hFF, 4'h3, 8'h00, 1, "skip_same");
      d = mk_full(16'h3000);
      d[95:80] = 16'hBEEF;
      apply(d, 8'hFF, 4'h3, 8'h20, 212, "skip_ch5");
`else
      apply(mk_full(16'h3000), 8'hFF, 4'h3, 8'hFF, 1668, "repeat_first");
      apply(mk_full(16'h3000), 8'hFF, 4'h3, 8'hFF, 1668, "repeat_same");
`endif

      check_eq("protocol", 32'(viol), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
